// File: rtl/alu_serial_exec_pkg.sv
// Shared definitions for the serial ALU execution stage and ALUcontrolLUT.
// Holds the ALU command encodings, the LUT muxindex values and the FSM
// state encodings. The control LUT and the benches use it as well.
package alu_serial_exec_pkg;

    typedef enum logic [2:0] {
        CMD_ADD  = 3'b000,
        CMD_SUB  = 3'b001,
        CMD_XOR  = 3'b010,
        CMD_SLT  = 3'b011,
        CMD_AND  = 3'b100,
        CMD_NAND = 3'b101,
        CMD_NOR  = 3'b110,
        CMD_OR   = 3'b111
    } cmd_e;

    // Datapath select driven by ALUcontrolLUT
    localparam logic [2:0] MUX_ADD = 3'd0;  // ADD, SUB
    localparam logic [2:0] MUX_XOR = 3'd1;
    localparam logic [2:0] MUX_SLT = 3'd2;
    localparam logic [2:0] MUX_AND = 3'd3;  // AND, NAND
    localparam logic [2:0] MUX_OR  = 3'd4;  // OR, NOR

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_serial_exec_lut.sv
// ALUcontrolLUT: decodes a 3-bit ALU command into datapath controls.
// Ports:
//   command            in  3  ALU command
//   muxindex           out 3  datapath select (MUX_*)
//   invertB            out 1  invert operand B and preset the carry-in (SUB/SLT)
//   setFlag            out 1  carryout/overflow are meaningful (ADD/SUB/SLT)
//   secondaryOperation out 1  invert the logic result (NAND/NOR)
module ALUcontrolLUT
    import alu_serial_exec_pkg::*;
(
    input  logic [2:0] command,
    output logic [2:0] muxindex,
    output logic       invertB,
    output logic       setFlag,
    output logic       secondaryOperation
);

    always_comb begin
        muxindex           = MUX_ADD;
        invertB            = 1'b0;
        setFlag            = 1'b0;
        secondaryOperation = 1'b0;
        case (cmd_e'(command))
            CMD_ADD: setFlag = 1'b1;
            CMD_SUB: begin
                invertB = 1'b1;
                setFlag = 1'b1;
            end
            CMD_XOR: muxindex = MUX_XOR;
            CMD_SLT: begin
                muxindex = MUX_SLT;
                invertB  = 1'b1;
                setFlag  = 1'b1;
            end
            CMD_AND: muxindex = MUX_AND;
            CMD_NAND: begin
                muxindex           = MUX_AND;
                secondaryOperation = 1'b1;
            end
            CMD_NOR: begin
                muxindex           = MUX_OR;
                secondaryOperation = 1'b1;
            end
            CMD_OR: muxindex = MUX_OR;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_serial_exec.sv
// alu_serial_exec: multi-cycle ALU that evaluates SLICE bits per cycle, LSB first.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cmdValid/cmdReady             request handshake
//   command, operandA, operandB   request payload, sampled on accept
//   resultValid/resultReady       result handshake
//   result, carryout, overflow, zero   registered outputs, updated on DONE entry
module alu_serial_exec
    import alu_serial_exec_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmdValid,
    output logic             cmdReady,
    input  logic [2:0]       command,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             resultValid,
    input  logic             resultReady,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (WIDTH % SLICE != 0) begin : g_width_check
        $error("alu_serial_exec: WIDTH must be a multiple of SLICE");
    end

    state_e             state;
    logic [2:0]         cmd_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   work_q;
    logic               carry_q;
    logic [CNT_W-1:0]   slice_count;

    logic [2:0]         muxindex;
    logic               invert_b;
    logic               set_flag;
    logic               secondary_op;

    ALUcontrolLUT u_lut (
        .command            (cmd_q),
        .muxindex           (muxindex),
        .invertB            (invert_b),
        .setFlag            (set_flag),
        .secondaryOperation (secondary_op)
    );

    logic [SLICE-1:0]   a_s;
    logic [SLICE-1:0]   b_x;
    logic               carry_in;
    logic [SLICE:0]     sum;
    logic               c_into_msb;
    logic               ovf;
    logic               slt_bit;
    logic [SLICE-1:0]   slice_out;
    logic [WIDTH-1:0]   work_shift;
    logic [WIDTH-1:0]   final_res;
    logic               last_slice;

    always_comb begin
        a_s = a_q[SLICE-1:0];
        b_x = b_q[SLICE-1:0] ^ {SLICE{invert_b}};
        // The first slice takes invertB as carry-in (two's complement +1 for SUB/SLT)
        carry_in   = (slice_count == '0) ? invert_b : carry_q;
        sum        = {1'b0, a_s} + {1'b0, b_x} + (SLICE+1)'(carry_in);
        c_into_msb = a_s[SLICE-1] ^ b_x[SLICE-1] ^ sum[SLICE-1];
        ovf        = c_into_msb ^ sum[SLICE];
        slt_bit    = sum[SLICE-1] ^ ovf;

        case (muxindex)
            MUX_ADD, MUX_SLT: slice_out = sum[SLICE-1:0];
            MUX_XOR:          slice_out = a_s ^ b_x;
            MUX_AND:          slice_out = a_s & b_x;
            MUX_OR:           slice_out = a_s | b_x;
            default:          slice_out = '0;
        endcase
        if (secondary_op) begin
            slice_out = ~slice_out;
        end

        // Result fills from the top; after NSLICE shifts slice 0 sits at bit 0
        work_shift = (work_q >> SLICE) | (WIDTH'(slice_out) << (WIDTH - SLICE));
        final_res  = (muxindex == MUX_SLT) ? WIDTH'(slt_bit) : work_shift;
        last_slice = (slice_count == CNT_W'(NSLICE - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cmdReady    <= 1'b0;
            resultValid <= 1'b0;
            result      <= '0;
            carryout    <= 1'b0;
            overflow    <= 1'b0;
            zero        <= 1'b0;
            cmd_q       <= 3'b000;
            a_q         <= '0;
            b_q         <= '0;
            work_q      <= '0;
            carry_q     <= 1'b0;
            slice_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmdReady <= 1'b1;
                    if (cmdValid && cmdReady) begin
                        cmd_q       <= command;
                        a_q         <= operandA;
                        b_q         <= operandB;
                        work_q      <= '0;
                        carry_q     <= 1'b0;
                        slice_count <= '0;
                        cmdReady    <= 1'b0;
                        state       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    a_q         <= a_q >> SLICE;
                    b_q         <= b_q >> SLICE;
                    work_q      <= work_shift;
                    carry_q     <= sum[SLICE];
                    slice_count <= slice_count + CNT_W'(1);
                    if (last_slice) begin
                        result      <= final_res;
                        carryout    <= set_flag & sum[SLICE];
                        overflow    <= set_flag & ovf;
                        zero        <= (final_res == '0);
                        resultValid <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (resultReady) begin
                        resultValid <= 1'b0;
                        cmdReady    <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    cmdReady <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_exec.sv
// Self-checking bench for alu_serial_exec with a reference model and
// an expected-result queue.
module tb_alu_serial_exec;
    import alu_serial_exec_pkg::*;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 8;
    localparam int NSLICE = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmdValid;
    logic             cmdReady;
    logic [2:0]       command;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic             resultValid;
    logic             resultReady;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             overflow;
    logic             zero;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    alu_serial_exec #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmdValid    (cmdValid),
        .cmdReady    (cmdReady),
        .command     (command),
        .operandA    (operandA),
        .operandB    (operandB),
        .resultValid (resultValid),
        .resultReady (resultReady),
        .result      (result),
        .carryout    (carryout),
        .overflow    (overflow),
        .zero        (zero)
    );

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             o;
        logic             z;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t model(input logic [2:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t        e;
        logic [WIDTH:0] s;
        e = '0;
        case (c)
            3'b000: begin
                s     = {1'b0, a} + {1'b0, b};
                e.res = s[WIDTH-1:0];
                e.c   = s[WIDTH];
                e.o   = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
            end
            3'b001, 3'b011: begin
                s   = {1'b0, a} + {1'b0, ~b} + 1;
                e.c = s[WIDTH];
                e.o = (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
                if (c == 3'b001) e.res = s[WIDTH-1:0];
                else             e.res = ($signed(a) < $signed(b)) ? 1 : 0;
            end
            3'b010:  e.res = a ^ b;
            3'b100:  e.res = a & b;
            3'b101:  e.res = ~(a & b);
            3'b110:  e.res = ~(a | b);
            default: e.res = a | b;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Drive one request at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit push);
        int n = 0;
        while (!cmdReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        cmdValid = 1'b1;
        command  = c;
        operandA = a;
        operandB = b;
        if (push) sb.push_back(model(c, a, b));
        @(negedge clk);
        cmdValid = 1'b0;
    endtask

    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!resultValid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic take_result();
        resultReady = 1'b1;
        @(negedge clk);
        resultReady = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmdValid = 1'b0; resultReady = 1'b0;
        command = 3'b000; operandA = '0; operandB = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({cmdReady, resultValid, result, carryout, overflow, zero} !== '0) begin
            failed++;
            $display("FAIL reset_values: got rdy=%b vld=%b res=%h c=%b o=%b z=%b want all 0",
                     cmdReady, resultValid, result, carryout, overflow, zero);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (cmdReady !== 1'b1) begin
            failed++;
            $display("FAIL reset_release_ready: got %b want 1", cmdReady);
        end
    endtask

    // Shared body for table-driven ops with one-cycle handshake afterwards
    task automatic run_table_op(input string name, input logic [2:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int   cyc;
        exp_t e;
        issue(c, a, b, 1'b1);
        wait_result(cyc);
        tests++;
        if (cyc !== NSLICE) begin
            failed++;
            $display("FAIL %s_latency: got %0d want %0d", name, cyc, NSLICE);
        end
        e = sb.pop_front();
        tests++;
        if ({result, carryout, overflow, zero} !== {e.res, e.c, e.o, e.z}) begin
            failed++;
            $display("FAIL %s_value: got res=%h c=%b o=%b z=%b want res=%h c=%b o=%b z=%b",
                     name, result, carryout, overflow, zero, e.res, e.c, e.o, e.z);
        end
        take_result();
    endtask

    task automatic test_arith();
        run_table_op("add_ovf", 3'b000, 32'h7FFFFFFF, 32'h00000001);
        tests++;
        if ({result, overflow, carryout, zero} !== {32'h80000000, 1'b1, 1'b0, 1'b0}) begin
            failed++;
            $display("FAIL add_ovf_const: got res=%h o=%b c=%b z=%b want 80000000 1 0 0",
                     result, overflow, carryout, zero);
        end
        run_table_op("sub_zero", 3'b001, 32'h00000005, 32'h00000005);
        tests++;
        if ({result, zero, carryout, overflow} !== {32'h0, 1'b1, 1'b1, 1'b0}) begin
            failed++;
            $display("FAIL sub_zero_const: got res=%h z=%b c=%b o=%b want 0 1 1 0",
                     result, zero, carryout, overflow);
        end
        run_table_op("add_carry", 3'b000, 32'hFFFFFFFF, 32'h00000001);
        run_table_op("sub_neg", 3'b001, 32'h00000003, 32'h12345678);
    endtask

    task automatic test_slt();
        run_table_op("slt_neg_pos", 3'b011, 32'hFFFFFFFF, 32'h00000001);
        run_table_op("slt_ovf", 3'b011, 32'h80000000, 32'h7FFFFFFF);
        tests++;
        if ({result, overflow} !== {32'h1, 1'b1}) begin
            failed++;
            $display("FAIL slt_ovf_const: got res=%h o=%b want 00000001 1", result, overflow);
        end
        run_table_op("slt_pos_neg", 3'b011, 32'h00000001, 32'hFFFFFFFF);
        run_table_op("slt_equal", 3'b011, 32'h00ABCDEF, 32'h00ABCDEF);
    endtask

    task automatic test_logic();
        logic [2:0] cmds [5];
        string      names [5];
        cmds  = '{3'b100, 3'b101, 3'b111, 3'b110, 3'b010};
        names = '{"and", "nand", "or", "nor", "xor"};
        for (int i = 0; i < 5; i++) begin
            run_table_op(names[i], cmds[i], 32'hF0F0F0F0, 32'hFF00FF00);
        end
    endtask

    task automatic test_backpressure();
        int   cyc;
        exp_t e;
        logic [WIDTH+2:0] snap;
        bit   stable = 1'b1;
        bit   extra  = 1'b0;
        issue(3'b000, 32'h7FFFFFFF, 32'h00000001, 1'b1);
        wait_result(cyc);
        e = sb.pop_front();
        tests++;
        if ({result, carryout, overflow, zero} !== {e.res, e.c, e.o, e.z}) begin
            failed++;
            $display("FAIL bp_value: got res=%h want res=%h", result, e.res);
        end
        snap = {result, carryout, overflow, zero};
        for (int i = 0; i < 3; i++) begin
            cmdValid = (i == 1);
            command  = 3'b010;
            operandA = 32'hDEADBEEF;
            operandB = 32'h12345678;
            @(negedge clk);
            if (!resultValid || cmdReady || ({result, carryout, overflow, zero} !== snap)) stable = 1'b0;
        end
        cmdValid = 1'b0;
        tests++;
        if (!stable) begin
            failed++;
            $display("FAIL bp_hold: got vld=%b rdy=%b res=%h want vld=1 rdy=0 res=%h",
                     resultValid, cmdReady, result, snap[WIDTH+2:3]);
        end
        take_result();
        repeat (10) begin
            @(negedge clk);
            if (resultValid) extra = 1'b1;
        end
        tests++;
        if (extra) begin
            failed++;
            $display("FAIL bp_ignored_cmd: got extra resultValid=1 want 0");
        end
    endtask

    task automatic test_reset_mid();
        issue(3'b000, 32'h11111111, 32'h22222222, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({cmdReady, resultValid, result, carryout, overflow, zero} !== '0) begin
            failed++;
            $display("FAIL reset_mid: got rdy=%b vld=%b res=%h c=%b o=%b z=%b want all 0",
                     cmdReady, resultValid, result, carryout, overflow, zero);
        end
        reset = 1'b0;
        @(negedge clk);
        run_table_op("post_reset_add", 3'b000, 32'd2, 32'd3);
        tests++;
        if (result !== 32'd5) begin
            failed++;
            $display("FAIL post_reset_const: got %h want 00000005", result);
        end
    endtask

    task automatic test_back_to_back();
        int         cyc;
        exp_t       e;
        logic [2:0] c;
        logic [WIDTH-1:0] a, b;
        resultReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            c = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            issue(c, a, b, 1'b1);
            wait_result(cyc);
            e = sb.pop_front();
            tests++;
            if ((cyc !== NSLICE) || ({result, carryout, overflow, zero} !== {e.res, e.c, e.o, e.z})) begin
                failed++;
                $display("FAIL b2b_%0d: cmd=%0d got lat=%0d res=%h c=%b o=%b z=%b want lat=%0d res=%h c=%b o=%b z=%b",
                         i, c, cyc, result, carryout, overflow, zero, NSLICE, e.res, e.c, e.o, e.z);
            end
            @(negedge clk);
            tests++;
            if ({resultValid, cmdReady} !== 2'b01) begin
                failed++;
                $display("FAIL b2b_single_cycle_%0d: got vld=%b rdy=%b want vld=0 rdy=1",
                         i, resultValid, cmdReady);
            end
        end
        resultReady = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_slt();
        test_logic();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
